// File: rtl/instr_sequencer.sv
// Fetch/sequencing controller: owns the program counter and run state,
// qualifies each decoded instruction with one execute-enable, applies
// jumps, and stalls the PC while a data-memory load is in flight.
module instr_sequencer #(
    parameter int PC_W     = 10,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             instr_halt,
    input  logic             is_mem_rd,
    input  logic             pc_jmp_en,
    input  logic [PC_W-1:0]  jmp_target,
    output logic [PC_W-1:0]  prog_ctr,
    output logic             instr_valid,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {IDLE, RUN, MEMWAIT, DONE} state_t;

    // With zero latency a load is an ordinary single-cycle instruction.
    localparam logic           HAS_WAIT  = (LOAD_LAT > 0);
    localparam logic [2:0]     WAIT_INIT = (LOAD_LAT > 0) ? 3'(LOAD_LAT - 1) : 3'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [2:0]      wait_cnt, wait_nxt;
    logic            cnt_clr;
    logic            load;
    logic            running;

    assign load    = is_mem_rd & HAS_WAIT;
    assign running = (state == RUN) || (state == MEMWAIT);

    // Next-state, next-PC and the combinational execute qualifiers.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = prog_ctr;
        wait_nxt    = wait_cnt;
        cnt_clr     = 1'b0;
        instr_valid = 1'b0;
        stall       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                    cnt_clr   = 1'b1;
                end
            end
            RUN: begin
                instr_valid = !load;
                stall       = load;
                if (instr_halt) begin
                    state_nxt = DONE;
                end else if (load) begin
                    // Hold the PC; the load's jump decode is meaningless.
                    state_nxt = MEMWAIT;
                    wait_nxt  = WAIT_INIT;
                end else if (pc_jmp_en) begin
                    pc_nxt = jmp_target;
                end else begin
                    pc_nxt = prog_ctr + PC_W'(1);
                end
            end
            MEMWAIT: begin
                if (wait_cnt != 3'd0) begin
                    stall    = 1'b1;
                    wait_nxt = wait_cnt - 3'd1;
                end else begin
                    // Read data valid now: retire the load and move on.
                    instr_valid = 1'b1;
                    pc_nxt      = prog_ctr + PC_W'(1);
                    state_nxt   = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, PC and the registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            prog_ctr <= '0;
            wait_cnt <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            prog_ctr <= pc_nxt;
            wait_cnt <= wait_nxt;
            busy     <= (state_nxt == RUN) || (state_nxt == MEMWAIT);
            done     <= (state_nxt == DONE);
        end
    end

    // Saturating run-cycle and retired-instruction counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else if (cnt_clr) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (running && cycle_count != CNT_MAX)
                cycle_count <= cycle_count + CNT_W'(1);
            if (instr_valid && instr_count != CNT_MAX)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/sequencing controller for the 9-bit core. Owns the program counter and run state, and qualifies every decoded instruction with a single execute-enable.
- Applies jumps from the control decoder's pc_jmp_en and the jump-LUT target. Stalls the PC for multi-cycle data-memory loads (ldr/ldi).
- Provides the start/done handshake to the test harness, plus cycle and instruction counters.

Parameters:
PC_W, 10, program counter width; PC wraps modulo 2^PC_W.
LOAD_LAT, 1, extra wait cycles a data-memory read needs before read data is valid (0 to 7).
CNT_W, 16, width of cycle_count and instr_count.

Ports:
clk  input  1  system clock, all state on rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  level/pulse; sampled only in IDLE or DONE; begins a program run at PC 0.
instr_halt  input  1  decoded halt for the instruction at prog_ctr.
is_mem_rd  input  1  decoded ldr/ldi for the instruction at prog_ctr.
pc_jmp_en  input  1  jump-taken from the control decoder (flags already applied).
jmp_target  input  PC_W  absolute target from the jump LUT.
prog_ctr  output  PC_W  instruction memory address.
instr_valid  output  1  execute enable; reg/data-memory writes are ANDed with this.
stall  output  1  high while a load is waiting on data memory.
busy  output  1  high in RUN or MEMWAIT.
done  output  1  high in DONE until the next start.
cycle_count  output  CNT_W  cycles spent in RUN+MEMWAIT in the current or last run.
instr_count  output  CNT_W  instructions retired in the current or last run.

Behaviour:
- States: IDLE, RUN, MEMWAIT, DONE.
- Reset (asynchronous, any state):
  - state=IDLE, prog_ctr=0, wait_cnt=0, both counters=0.
  - All 1-bit outputs low.
  - Reset mid-run abandons the run; no write is qualified after reset_n falls.
- IDLE:
  - instr_valid=0; the PC holds.
  - start=1 -> next cycle state=RUN, prog_ctr=0, counters cleared.
- RUN, with a combinational "load" = is_mem_rd and LOAD_LAT>0:
  - instr_valid = !load; stall = load.
  - Rising-edge priority: instr_halt > load > pc_jmp_en > increment.
  - instr_halt=1 -> DONE. The PC holds and the halt instruction counts as retired.
  - load -> MEMWAIT with wait_cnt=LOAD_LAT-1. The PC holds. pc_jmp_en is ignored.
  - pc_jmp_en=1 -> prog_ctr=jmp_target.
  - Otherwise -> prog_ctr=prog_ctr+1, wrapping from 2^PC_W-1 to 0.
- MEMWAIT:
  - busy=1.
  - wait_cnt!=0: instr_valid=0, stall=1, decrement wait_cnt.
  - wait_cnt==0: instr_valid=1, stall=0, so the load's register write happens this cycle. Next edge: prog_ctr+1 (loads never jump), back to RUN.
  - A load therefore occupies LOAD_LAT+1 cycles. The instruction inputs are assumed stable because the PC is held.
- DONE:
  - done=1, busy=0, instr_valid=0; the PC and counters hold.
  - start=1 -> RUN next cycle with prog_ctr=0, counters cleared, done drops.
- start in RUN or MEMWAIT is ignored.
- Counters:
  - cycle_count +1 every cycle in RUN or MEMWAIT.
  - instr_count +1 every cycle with instr_valid=1.
  - Both saturate at 2^CNT_W-1 (no wrap).
- LOAD_LAT=0: loads are treated as single-cycle RUN instructions; MEMWAIT is unreachable.
- Outputs prog_ctr, busy, done and the counters are registered. instr_valid and stall are combinational from the state and the current decode inputs.

Test Plan:
- Reset then start pulse, no jumps/loads, halt at PC 5 -> prog_ctr 0..5, done=1 from cycle 7, instr_count=6, cycle_count=6; the PC holds at 5.
- Jump at PC 3 with jmp_target=40, halt at 41 -> PC sequence 0,1,2,3,40,41; instr_count=6.
- LOAD_LAT=2, is_mem_rd at PC 2 -> stall high for 2 cycles, instr_valid low for those cycles and high on the third, prog_ctr stays 2 for 3 cycles then 3; cycle_count increases by 3 for the load.
- Simultaneous instr_halt, is_mem_rd and pc_jmp_en at PC 4 -> DONE next cycle, prog_ctr=4, no MEMWAIT entry.
- PC_W=4 with no halt until after wrap -> prog_ctr 15 then 0.
- reset_n low during MEMWAIT -> immediately state IDLE, prog_ctr=0, instr_valid=0, counters 0.
- start held high in RUN -> no restart.
- start in DONE -> restart at PC 0 with cleared counters.
